// File: rtl/wb_timer_sched_pkg.sv
// Shared types and register maps for the Wishbone timer channel scheduler.
// Holds the sequencer state enum, the register word addresses and the timer access record.
package wb_timer_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI0, S_RD_LO, S_RD_HI1, S_SCAN, S_WR_HMAX, S_WR_LO, S_WR_HI
  } state_e;

  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_STATUS  = 4'd1;
  localparam logic [3:0] REG_DL_BASE = 4'd2;

  localparam int STS_BUSY_BIT = 8;
  localparam int STS_ERR_BIT  = 9;

  localparam logic [7:0] TMR_MTIME_LO = 8'd0;
  localparam logic [7:0] TMR_MTIME_HI = 8'd1;
  localparam logic [7:0] TMR_CMP_LO   = 8'd2;
  localparam logic [7:0] TMR_CMP_HI   = 8'd3;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } tmr_req_t;

  function automatic logic [31:0] byte_merge(logic [31:0] old, logic [31:0] wdat, logic [3:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  // Timer bus access issued on entry to each sequencer state.
  function automatic tmr_req_t req_for(state_e s, logic [63:0] tgt);
    tmr_req_t r;
    r = '{we: 1'b0, addr: TMR_MTIME_HI, data: 32'h0};
    case (s)
      S_RD_LO:   r.addr = TMR_MTIME_LO;
      S_WR_HMAX: r = '{we: 1'b1, addr: TMR_CMP_HI, data: 32'hFFFF_FFFF};
      S_WR_LO:   r = '{we: 1'b1, addr: TMR_CMP_LO, data: tgt[31:0]};
      S_WR_HI:   r = '{we: 1'b1, addr: TMR_CMP_HI, data: tgt[63:32]};
      default:   ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_timer_sched_min.sv
// Combinational expiry detect and earliest-deadline finder across all channels.
// Expired channels are excluded from the minimum so the next compare targets a future deadline.
module wb_timer_sched_min #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0][63:0] deadline,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [63:0]             mtime,
  output logic [NUM_CH-1:0]       expired,
  output logic [63:0]             target
);

  logic [NUM_CH-1:0] live;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_exp
      assign expired[g] = enable[g] && (deadline[g] <= mtime);
    end
  endgenerate

  assign live = enable & ~expired;

  // Strict compare while walking upward keeps the lowest index on ties.
  always_comb begin
    logic found;
    found  = 1'b0;
    target = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (live[i] && (!found || deadline[i] < target)) begin
        target = deadline[i];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_timer_sched.sv
// Multiplexes NUM_CH virtual deadlines onto one mtime/mtimecmp timer over Wishbone.
// CPU-side slave holds config; a master sequencer snapshots mtime, expires channels, reprograms mtimecmp.
module wb_timer_sched
  import wb_timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_addr_i,
  input  logic [31:0]       wb_data_i,
  input  logic [3:0]        wb_sel_i,
  output logic              wb_stall_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [31:0]       wb_data_o,
  output logic              tmr_cyc_o,
  output logic              tmr_stb_o,
  output logic              tmr_we_o,
  output logic [7:0]        tmr_addr_o,
  output logic [31:0]       tmr_data_o,
  output logic [3:0]        tmr_sel_o,
  input  logic              tmr_stall_i,
  input  logic              tmr_ack_i,
  input  logic              tmr_err_i,
  input  logic [31:0]       tmr_data_i,
  input  logic              timer_irq_i,
  output logic [NUM_CH-1:0] ch_irq_o,
  output logic              irq_o
);

  localparam logic [4:0] DL_END = 5'(2 + 2*NUM_CH);

  state_e                  state;
  logic [NUM_CH-1:0]       ctrl, pending, expired, ctrl_wval, w1c;
  logic [NUM_CH-1:0][63:0] deadline;
  logic                    dirty, err, busy, wb_acc, wb_wr, cfg_wr, err_clr, done;
  logic [31:0]             hi0, lo, rdata;
  logic [63:0]             target, scan_target;

  assign wb_stall_o = 1'b0;
  assign wb_err_o   = 1'b0;
  assign ch_irq_o   = pending;
  assign irq_o      = |pending;

  assign wb_acc    = wb_cyc_i & wb_stb_i;
  assign wb_wr     = wb_acc & wb_we_i;
  assign busy      = (state != S_IDLE);
  assign cfg_wr    = wb_wr && (wb_addr_i == REG_CTRL ||
                     (wb_addr_i >= REG_DL_BASE && {1'b0, wb_addr_i} < DL_END));
  assign ctrl_wval = wb_sel_i[0] ? wb_data_i[NUM_CH-1:0] : ctrl;
  assign w1c       = (wb_wr && wb_addr_i == REG_STATUS && wb_sel_i[0]) ? wb_data_i[NUM_CH-1:0] : '0;
  assign err_clr   = wb_wr && wb_addr_i == REG_STATUS && wb_sel_i[1] && wb_data_i[STS_ERR_BIT];
  assign done      = tmr_cyc_o & tmr_ack_i;

  always_comb begin
    rdata = '0;
    case (wb_addr_i)
      REG_CTRL:   rdata[NUM_CH-1:0] = ctrl;
      REG_STATUS: begin
        rdata[NUM_CH-1:0]   = pending;
        rdata[STS_BUSY_BIT] = busy;
        rdata[STS_ERR_BIT]  = err;
      end
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (wb_addr_i == 4'(2 + 2*n)) rdata = deadline[n][31:0];
          if (wb_addr_i == 4'(3 + 2*n)) rdata = deadline[n][63:32];
        end
      end
    endcase
  end

  wb_timer_sched_min #(.NUM_CH(NUM_CH)) u_min (
    .deadline (deadline),
    .enable   (ctrl),
    .mtime    ({hi0, lo}),
    .expired  (expired),
    .target   (scan_target)
  );

  // CPU-side register file; a CTRL write overrides the SCAN auto-disable in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
      ctrl      <= '0;
      pending   <= '0;
      deadline  <= '0;
    end else begin
      wb_ack_o  <= wb_acc;
      wb_data_o <= (wb_acc && !wb_we_i) ? rdata : '0;
      if (wb_wr && wb_addr_i == REG_CTRL) ctrl <= ctrl_wval;
      else if (state == S_SCAN)           ctrl <= ctrl & ~expired;
      pending <= (pending & ~w1c) | ((state == S_SCAN) ? expired : '0);
      for (int n = 0; n < NUM_CH; n++) begin
        if (wb_wr && wb_addr_i == 4'(2 + 2*n))
          deadline[n][31:0]  <= byte_merge(deadline[n][31:0], wb_data_i, wb_sel_i);
        if (wb_wr && wb_addr_i == 4'(3 + 2*n))
          deadline[n][63:32] <= byte_merge(deadline[n][63:32], wb_data_i, wb_sel_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      dirty      <= 1'b1;
      err        <= 1'b0;
      tmr_cyc_o  <= 1'b0;
      tmr_stb_o  <= 1'b0;
      tmr_we_o   <= 1'b0;
      tmr_addr_o <= '0;
      tmr_data_o <= '0;
      tmr_sel_o  <= '0;
      hi0        <= '0;
      lo         <= '0;
      target     <= '0;
    end else begin
      tmr_sel_o <= 4'hF;
      if (err_clr) err <= 1'b0;
      if (state == S_IDLE && (dirty || timer_irq_i)) dirty <= 1'b0;
      if (cfg_wr) dirty <= 1'b1;
      if (tmr_stb_o && !tmr_stall_i) tmr_stb_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (dirty || timer_irq_i) begin
            state <= S_RD_HI0;
            {tmr_we_o, tmr_addr_o, tmr_data_o} <= req_for(S_RD_HI0, target);
            tmr_cyc_o <= 1'b1;
            tmr_stb_o <= 1'b1;
          end
        end
        S_SCAN: begin
          target <= scan_target;
          state  <= S_WR_HMAX;
          {tmr_we_o, tmr_addr_o, tmr_data_o} <= req_for(S_WR_HMAX, scan_target);
          tmr_cyc_o <= 1'b1;
          tmr_stb_o <= 1'b1;
        end
        default: begin
          if (tmr_cyc_o && tmr_err_i) begin
            err       <= 1'b1;
            tmr_cyc_o <= 1'b0;
            tmr_stb_o <= 1'b0;
            state     <= S_IDLE;
          end else if (done) begin
            tmr_stb_o <= 1'b1;
            case (state)
              S_RD_HI0: begin
                hi0   <= tmr_data_i;
                state <= S_RD_LO;
                {tmr_we_o, tmr_addr_o, tmr_data_o} <= req_for(S_RD_LO, target);
              end
              S_RD_LO: begin
                lo    <= tmr_data_i;
                state <= S_RD_HI1;
                {tmr_we_o, tmr_addr_o, tmr_data_o} <= req_for(S_RD_HI1, target);
              end
              S_RD_HI1: begin
                // A changed high word means lo may have wrapped: re-read lo against the new hi.
                if (tmr_data_i != hi0) begin
                  hi0   <= tmr_data_i;
                  state <= S_RD_LO;
                  {tmr_we_o, tmr_addr_o, tmr_data_o} <= req_for(S_RD_LO, target);
                end else begin
                  state     <= S_SCAN;
                  tmr_cyc_o <= 1'b0;
                  tmr_stb_o <= 1'b0;
                end
              end
              S_WR_HMAX: begin
                state <= S_WR_LO;
                {tmr_we_o, tmr_addr_o, tmr_data_o} <= req_for(S_WR_LO, target);
              end
              S_WR_LO: begin
                state <= S_WR_HI;
                {tmr_we_o, tmr_addr_o, tmr_data_o} <= req_for(S_WR_HI, target);
              end
              default: begin
                state     <= S_IDLE;
                tmr_cyc_o <= 1'b0;
                tmr_stb_o <= 1'b0;
                tmr_we_o  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_timer_sched.sv
// Directed bench for wb_timer_sched with a behavioural mtime/mtimecmp timer slave.
module tb_wb_timer_sched;
  localparam int NUM_CH = 4;
  localparam logic [63:0] MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]        wb_addr_i, wb_sel_i;
  logic [31:0]       wb_data_i, wb_data_o;
  logic              wb_stall_o, wb_ack_o, wb_err_o;
  logic              tmr_cyc_o, tmr_stb_o, tmr_we_o;
  logic [7:0]        tmr_addr_o;
  logic [31:0]       tmr_data_o;
  logic [3:0]        tmr_sel_o;
  logic              tmr_stall_i = 1'b0, tmr_ack_i = 1'b0, tmr_err_i = 1'b0;
  logic [31:0]       tmr_data_i = '0;
  logic              timer_irq_i;
  logic [NUM_CH-1:0] ch_irq_o;
  logic              irq_o;

  int total = 0;
  int bad = 0;

  wb_timer_sched #(.NUM_CH(NUM_CH)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_sel_i(wb_sel_i),
    .wb_stall_o(wb_stall_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_data_o(wb_data_o),
    .tmr_cyc_o(tmr_cyc_o), .tmr_stb_o(tmr_stb_o), .tmr_we_o(tmr_we_o),
    .tmr_addr_o(tmr_addr_o), .tmr_data_o(tmr_data_o), .tmr_sel_o(tmr_sel_o),
    .tmr_stall_i(tmr_stall_i), .tmr_ack_i(tmr_ack_i), .tmr_err_i(tmr_err_i), .tmr_data_i(tmr_data_i),
    .timer_irq_i(timer_irq_i), .ch_irq_o(ch_irq_o), .irq_o(irq_o)
  );

  // Timer slave model: mtime owned by the stimulus, mtimecmp and counters by the model.
  logic [63:0] mtime = 64'd1000;
  logic [63:0] mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        stall_en = 1'b0, err_arm = 1'b0, err_fired = 1'b0;
  int          hi_reads = 0, lo_reads = 0;
  logic [39:0] wlog[$];

  assign timer_irq_i = (mtime >= mtimecmp);

  always @(posedge clk) begin
    tmr_ack_i   <= 1'b0;
    tmr_err_i   <= 1'b0;
    tmr_stall_i <= stall_en ? ~tmr_stall_i : 1'b0;
    if (!rst && tmr_cyc_o && tmr_stb_o && !tmr_stall_i) begin
      if (tmr_we_o) begin
        if (err_arm && !err_fired && tmr_addr_o == 8'd2) begin
          tmr_err_i <= 1'b1;
          err_fired <= 1'b1;
        end else begin
          tmr_ack_i <= 1'b1;
          wlog.push_back({tmr_addr_o, tmr_data_o});
          if (tmr_addr_o == 8'd2) mtimecmp[31:0]  <= tmr_data_o;
          if (tmr_addr_o == 8'd3) mtimecmp[63:32] <= tmr_data_o;
        end
      end else begin
        tmr_ack_i <= 1'b1;
        if (tmr_addr_o == 8'd0) begin tmr_data_i <= mtime[31:0];  lo_reads++; end
        if (tmr_addr_o == 8'd1) begin tmr_data_i <= mtime[63:32]; hi_reads++; end
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output logic ack);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_addr_i = a; wb_data_i = d; wb_sel_i = s;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    ack = wb_ack_o;
    r = wb_data_o;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic k;
    wb_xfer(1'b1, a, d, 4'hF, r, k);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] r);
    logic k;
    wb_xfer(1'b0, a, 32'h0, 4'hF, r, k);
  endtask

  // Two back-to-back idle STATUS reads rule out the one-cycle IDLE gap before a re-run.
  task automatic wait_idle(output logic ok);
    logic [31:0] s;
    int quiet;
    ok = 1'b0;
    quiet = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 400 && !ok; i++) begin
      rd(4'd1, s);
      if (!s[8]) quiet++; else quiet = 0;
      if (quiet >= 2) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic ok;
    logic [31:0] r;
    int n0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", wb_ack_o); end
    total++; if (wb_data_o !== 32'h0) begin bad++; $display("FAIL rst_wbdata got=%h want=0", wb_data_o); end
    total++; if ({tmr_cyc_o, tmr_stb_o, tmr_we_o, tmr_addr_o, tmr_data_o, tmr_sel_o} !== 47'h0) begin
      bad++; $display("FAIL rst_tmr got=%b%b%b %h %h %h want=0", tmr_cyc_o, tmr_stb_o, tmr_we_o, tmr_addr_o, tmr_data_o, tmr_sel_o); end
    total++; if ({ch_irq_o, irq_o} !== 5'h0) begin bad++; $display("FAIL rst_irq got=%b%b want=0", ch_irq_o, irq_o); end
    n0 = wlog.size();
    rst = 1'b0;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_idle timeout got=busy want=idle"); end
    total++; if (wlog.size() - n0 !== 3) begin bad++; $display("FAIL rst_nwr got=%0d want=3", wlog.size() - n0); end
    if (wlog.size() - n0 == 3) begin
      total++; if ({wlog[n0], wlog[n0+1], wlog[n0+2]} !== {8'd3, 32'hFFFF_FFFF, 8'd2, 32'hFFFF_FFFF, 8'd3, 32'hFFFF_FFFF}) begin
        bad++; $display("FAIL rst_seq got=%h %h %h want=03ffffffff 02ffffffff 03ffffffff", wlog[n0], wlog[n0+1], wlog[n0+2]); end
    end
    rd(4'd0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%h want=0", r); end
    rd(4'd1, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_status got=%h want=0", r); end
  endtask

  task automatic test_slave;
    logic ok, ack;
    logic [31:0] r;
    wb_xfer(1'b1, 4'd2, 32'hAABB_CCDD, 4'b0011, r, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL sl_ack got=%b want=1", ack); end
    @(negedge clk);
    total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL sl_ack_once got=%b want=0", wb_ack_o); end
    total++; if ({wb_stall_o, wb_err_o} !== 2'b00) begin bad++; $display("FAIL sl_stall_err got=%b%b want=00", wb_stall_o, wb_err_o); end
    rd(4'd2, r);
    total++; if (r !== 32'h0000_CCDD) begin bad++; $display("FAIL sl_bytesel got=%h want=0000ccdd", r); end
    wr(4'd12, 32'hFFFF_FFFF);
    rd(4'd12, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL sl_unmapped got=%h want=0", r); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL sl_idle timeout got=busy want=idle"); end
  endtask

  task automatic test_two_ch;
    logic ok;
    logic [31:0] r;
    mtime = 64'd1000;
    wr(4'd2, 32'd5000); wr(4'd3, 32'd0);
    wr(4'd4, 32'd3000); wr(4'd5, 32'd0);
    wr(4'd0, 32'd3);
    wait_idle(ok);
    total++; if (mtimecmp !== 64'd3000) begin bad++; $display("FAIL two_cmp1 got=%0d want=3000 ok=%b", mtimecmp, ok); end
    total++; if (ch_irq_o !== 4'b0000) begin bad++; $display("FAIL two_irq0 got=%b want=0000", ch_irq_o); end
    mtime = 64'd3000;
    wait_idle(ok);
    total++; if ({ch_irq_o, irq_o} !== 5'b0010_1) begin bad++; $display("FAIL two_irq got=%b%b want=00101 ok=%b", ch_irq_o, irq_o, ok); end
    rd(4'd0, r);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL two_ctrl got=%h want=1", r); end
    total++; if (mtimecmp !== 64'd5000) begin bad++; $display("FAIL two_cmp2 got=%0d want=5000", mtimecmp); end
    wr(4'd1, 32'h2);
    @(negedge clk);
    total++; if (ch_irq_o !== 4'b0000) begin bad++; $display("FAIL two_w1c got=%b want=0000", ch_irq_o); end
  endtask

  task automatic test_tie;
    logic ok;
    logic [31:0] r;
    mtime = 64'd100;
    wr(4'd6, 32'd2000); wr(4'd7, 32'd0);
    wr(4'd8, 32'd2000); wr(4'd9, 32'd0);
    wr(4'd0, 32'hC);
    wait_idle(ok);
    total++; if (mtimecmp !== 64'd2000) begin bad++; $display("FAIL tie_cmp got=%0d want=2000 ok=%b", mtimecmp, ok); end
    mtime = 64'd2000;
    wait_idle(ok);
    total++; if (ch_irq_o !== 4'b1100) begin bad++; $display("FAIL tie_pend got=%b want=1100 ok=%b", ch_irq_o, ok); end
    rd(4'd0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL tie_ctrl got=%h want=0", r); end
    total++; if (mtimecmp !== MAX64) begin bad++; $display("FAIL tie_max got=%h want=max", mtimecmp); end
    wr(4'd1, 32'h4);
    @(negedge clk);
    total++; if (ch_irq_o !== 4'b1000) begin bad++; $display("FAIL tie_w1c got=%b want=1000", ch_irq_o); end
    wr(4'd1, 32'hF);
  endtask

  task automatic test_past;
    logic ok;
    logic [31:0] r;
    mtime = 64'd800;
    wr(4'd2, 32'd500); wr(4'd3, 32'd0);
    wr(4'd0, 32'd1);
    wait_idle(ok);
    total++; if (ch_irq_o !== 4'b0001) begin bad++; $display("FAIL past_pend got=%b want=0001 ok=%b", ch_irq_o, ok); end
    total++; if (mtimecmp !== MAX64) begin bad++; $display("FAIL past_max got=%h want=max", mtimecmp); end
    rd(4'd0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL past_ctrl got=%h want=0", r); end
    wr(4'd1, 32'hF);
  endtask

  task automatic test_tear;
    logic ok, seen;
    int h0, l0;
    mtime = 64'h0000_0000_FFFF_FFF0;
    wr(4'd2, 32'd0); wr(4'd3, 32'd1);
    wait_idle(ok);
    h0 = hi_reads; l0 = lo_reads;
    wr(4'd0, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (hi_reads == h0 + 1) seen = 1'b1;
    end
    mtime = 64'h0000_0001_0000_0005;
    total++; if (!seen) begin bad++; $display("FAIL tear_hi0 timeout got=%0d want=%0d", hi_reads, h0 + 1); end
    wait_idle(ok);
    total++; if (hi_reads - h0 !== 3) begin bad++; $display("FAIL tear_hireads got=%0d want=3", hi_reads - h0); end
    total++; if (lo_reads - l0 !== 2) begin bad++; $display("FAIL tear_loreads got=%0d want=2", lo_reads - l0); end
    total++; if (ch_irq_o !== 4'b0001) begin bad++; $display("FAIL tear_pend got=%b want=0001 ok=%b", ch_irq_o, ok); end
    total++; if (mtimecmp !== MAX64) begin bad++; $display("FAIL tear_max got=%h want=max", mtimecmp); end
    wr(4'd1, 32'hF);
  endtask

  task automatic test_err;
    logic ok, ack;
    logic [31:0] r;
    int n0;
    mtime = 64'd100;
    wr(4'd4, 32'd3000); wr(4'd5, 32'd0);
    wait_idle(ok);
    n0 = wlog.size();
    err_arm = 1'b1;
    wr(4'd0, 32'd2);
    wait_idle(ok);
    repeat (10) @(negedge clk);
    err_arm = 1'b0;
    rd(4'd1, r);
    total++; if (r !== 32'h0000_0200) begin bad++; $display("FAIL err_status got=%h want=00000200 ok=%b", r, ok); end
    total++; if (wlog.size() - n0 !== 1) begin bad++; $display("FAIL err_nwr got=%0d want=1", wlog.size() - n0); end
    total++; if (tmr_cyc_o !== 1'b0) begin bad++; $display("FAIL err_cyc got=%b want=0", tmr_cyc_o); end
    total++; if (mtimecmp !== MAX64) begin bad++; $display("FAIL err_cmp got=%h want=max", mtimecmp); end
    wb_xfer(1'b1, 4'd1, 32'h0000_0200, 4'b0010, r, ack);
    rd(4'd1, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL err_w1c got=%h want=0", r); end
  endtask

  task automatic test_stall;
    logic ok;
    stall_en = 1'b1;
    wr(4'd4, 32'd2500);
    wait_idle(ok);
    stall_en = 1'b0;
    total++; if (mtimecmp !== 64'd2500) begin bad++; $display("FAIL stall_cmp got=%0d want=2500 ok=%b", mtimecmp, ok); end
  endtask

  task automatic test_back_to_back;
    logic ok;
    logic [31:0] r;
    wr(4'd4, 32'd2200);
    wr(4'd4, 32'd1800);
    rd(4'd1, r);
    total++; if (r[8] !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", r[8]); end
    wait_idle(ok);
    total++; if (mtimecmp !== 64'd1800) begin bad++; $display("FAIL b2b_cmp got=%0d want=1800 ok=%b", mtimecmp, ok); end
  endtask

  task automatic test_reset_mid;
    logic ok;
    logic [31:0] r;
    stall_en = 1'b1;
    wr(4'd0, 32'd2);
    repeat (3) @(negedge clk);
    total++; if (tmr_cyc_o !== 1'b1) begin bad++; $display("FAIL mid_active got=%b want=1", tmr_cyc_o); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({tmr_cyc_o, tmr_stb_o, wb_ack_o} !== 3'b000) begin bad++; $display("FAIL mid_abandon got=%b%b%b want=000", tmr_cyc_o, tmr_stb_o, wb_ack_o); end
    rst = 1'b0;
    stall_en = 1'b0;
    wait_idle(ok);
    rd(4'd0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_ctrl got=%h want=0", r); end
    total++; if (mtimecmp !== MAX64) begin bad++; $display("FAIL mid_cmp got=%h want=max ok=%b", mtimecmp, ok); end
  endtask

  initial begin
    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_addr_i = '0; wb_data_i = '0; wb_sel_i = '0;
    test_reset;
    test_slave;
    test_two_ch;
    test_tie;
    test_past;
    test_tear;
    test_err;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
